// File: rtl/aoi_pkg.sv
// aoi_pkg: shared state encoding, generalised AOI golden model and MISR step.
package aoi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Pairs (x0&x1), (x2&x3), ... are ORed; an odd top bit joins the OR alone.
    function automatic logic aoi_golden(input logic [15:0] vec, input int n);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 16; i += 2) begin
            if (i + 1 < n)
                acc = acc | (vec[i] & vec[i+1]);
            else if (i < n)
                acc = acc | vec[i];
        end
        return ~acc;
    endfunction

    // Callers truncate the result to their own signature width w.
    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] poly,
                                              input int w, input logic d);
        return (s << 1) ^ (s[w-1] ? poly : 32'd0) ^ {31'd0, d};
    endfunction

endpackage

// File: rtl/aoi_misr.sv
// aoi_misr: serial-input MISR that folds one response bit per enabled cycle.
module aoi_misr
    import aoi_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sig <= '0;
        else if (clr)
            sig <= '0;
        else if (en)
            sig <= SIG_W'(misr_step(32'(sig), 32'(POLY), SIG_W, din));
    end

endmodule

// File: rtl/aoi_bist.sv
// aoi_bist: exhaustive BIST sweeping 2^N_IN vectors into an external AOI and
// checking each latency-aligned response against the golden AOI function.
module aoi_bist
    import aoi_pkg::*;
#(
    parameter int               N_IN  = 5,
    parameter int               PIPE  = 0,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   x_out,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              aborted,
    output logic [N_IN:0]     err_cnt,
    output logic [N_IN-1:0]   first_fail,
    output logic [SIG_W-1:0]  sig
);

    localparam logic [N_IN-1:0] LAST = '1;

    state_t          state, nxt;
    logic            go, stop, active, tail_v, cmp, miss;
    logic [N_IN-1:0] tail_vec;
    logic [2:0]      dcnt;

    assign active = (state == RUN) || (state == DRAIN);
    assign go     = start && !active;
    assign stop   = abort && active;
    assign cmp    = tail_v && active && !stop;
    assign miss   = cmp && (aoi_golden(16'(tail_vec), N_IN) != y_in);

    always_comb begin
        nxt = state;
        if (go)
            nxt = RUN;
        else if (stop)
            nxt = DONE;
        else if (state == RUN && x_out == LAST)
            nxt = (PIPE > 0) ? DRAIN : DONE;
        else if (state == DRAIN && dcnt == 3'd0)
            nxt = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x_out      <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            aborted    <= 1'b0;
            dcnt       <= '0;
        end else begin
            state <= nxt;
            busy  <= (nxt == RUN) || (nxt == DRAIN);
            done  <= nxt == DONE;
            pass  <= (nxt == DONE) && !stop && !aborted && !miss && (err_cnt == '0);
            if (state == RUN)
                dcnt <= 3'(PIPE - 1);
            else if (state == DRAIN && dcnt != 3'd0)
                dcnt <= dcnt - 3'd1;
            if (go) begin
                x_out      <= '0;
                err_cnt    <= '0;
                first_fail <= '0;
                aborted    <= 1'b0;
            end else begin
                if (state == RUN && nxt == RUN)
                    x_out <= x_out + 1'b1;
                if (miss) begin
                    err_cnt <= err_cnt + 1'b1;
                    if (err_cnt == '0)
                        first_fail <= tail_vec;
                end
                if (stop)
                    aborted <= 1'b1;
            end
        end
    end

    // The delay line aligns each vector with the response the DUT returns PIPE cycles later.
    if (PIPE == 0) begin : g_comb
        assign tail_v   = state == RUN;
        assign tail_vec = x_out;
    end else begin : g_pipe
        logic [PIPE-1:0] dv;
        logic [N_IN-1:0] dvec [PIPE];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                dv <= '0;
            else
                dv <= go ? '0 : (dv << 1) | PIPE'(state == RUN);
        end
        always_ff @(posedge clk) begin
            dvec[0] <= x_out;
            for (int i = 1; i < PIPE; i++)
                dvec[i] <= dvec[i-1];
        end
        assign tail_v   = dv[PIPE-1];
        assign tail_vec = dvec[PIPE-1];
    end

    aoi_misr #(.SIG_W(SIG_W), .POLY(POLY)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .en    (cmp),
        .din   (y_in),
        .sig   (sig)
    );

endmodule

// File: tb/tb_aoi_bist.sv
// tb_aoi_bist: directed sweeps of a combinational (PIPE=0) and a registered (PIPE=2)
// AOI checker against a scoreboard of expected sweep results.
module tb_aoi_bist;

    localparam int N  = 5;
    localparam int NV = 32;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [N-1:0] x0, x2, ff0, ff2;
    logic         y0, y2, busy0, busy2, done0, done2, pass0, pass2, ab0, ab2;
    logic [N:0]   err0, err2;
    logic [15:0]  sig0, sig2;
    logic         r1, r2;
    int           mode = 0;
    bit           once = 1'b0;
    int           vectors = 0, miscompares = 0;

    typedef struct {
        int          lat;
        int          err;
        int          ff;
        logic [15:0] sig;
        bit          pass;
        bit          ab;
    } exp_t;

    exp_t q0[$], q2[$];

    always #5 clk = ~clk;

    function automatic logic g(input logic [N-1:0] v);
        return !((v[0] & v[1]) | (v[2] & v[3]) | v[4]);
    endfunction

    // mode 0: faithful, 1: stuck-at-0, 2: stuck-at-1
    function automatic logic resp(input int m, input logic gv);
        return m == 1 ? 1'b0 : m == 2 ? 1'b1 : gv;
    endfunction

    assign y0 = resp(mode, g(x0));
    always @(posedge clk) begin
        r1 <= g(x2);
        r2 <= r1;
    end
    assign y2 = resp(mode, once ? r1 : r2);

    aoi_bist #(.N_IN(N), .PIPE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_out(x0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .aborted(ab0), .err_cnt(err0),
        .first_fail(ff0), .sig(sig0)
    );

    aoi_bist #(.N_IN(N), .PIPE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_out(x2), .y_in(y2),
        .busy(busy2), .done(done2), .pass(pass2), .aborted(ab2), .err_cnt(err2),
        .first_fail(ff2), .sig(sig2)
    );

    // Vectors 0..last are compared; a single-register DUT at PIPE=2 answers with the next vector.
    function automatic exp_t model(input int m, input int last, input int pipe, input bit one,
                                   input bit ab);
        exp_t e;
        e.err = 0;
        e.ff  = 0;
        e.sig = 16'h0;
        e.ab  = ab;
        e.lat = NV + pipe + 2;
        for (int v = 0; v <= last; v++) begin
            logic gv, yv;
            gv = g(N'(v));
            yv = resp(m, one ? g(N'(v < NV - 1 ? v + 1 : v)) : gv);
            if (yv !== gv) begin
                if (e.err == 0) e.ff = v;
                e.err++;
            end
            e.sig = {e.sig[14:0], 1'b0} ^ (e.sig[15] ? 16'h1021 : 16'h0) ^ {15'h0, yv};
        end
        e.pass = (e.err == 0) && !ab;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input int m, input bit one, input bit dbl_start);
        exp_t e;
        int   cyc, lat0, lat2;
        q0.push_back(model(m, NV - 1, 0, 1'b0, 1'b0));
        q2.push_back(model(m, NV - 1, 2, one, 1'b0));
        mode = m;
        once = one;
        @(negedge clk);
        start = 1'b1;
        cyc   = 1;
        lat0  = 0;
        lat2  = 0;
        while ((lat0 == 0 || lat2 == 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = dbl_start && cyc == 12;
            if (cyc == 2) chk("busy_after_start", 32'(busy0), 32'd1);
            if (done0 && lat0 == 0) lat0 = cyc;
            if (done2 && lat2 == 0) lat2 = cyc;
        end
        start = 1'b0;
        e = q0.pop_front();
        chk("p0_latency", 32'(lat0), 32'(e.lat));
        chk("p0_err_cnt", 32'(err0), 32'(e.err));
        chk("p0_first_fail", 32'(ff0), 32'(e.ff));
        chk("p0_sig", 32'(sig0), 32'(e.sig));
        chk("p0_pass", 32'(pass0), 32'(e.pass));
        chk("p0_aborted", 32'(ab0), 32'(e.ab));
        chk("p0_busy_low", 32'(busy0), 32'd0);
        e = q2.pop_front();
        chk("p2_latency", 32'(lat2), 32'(e.lat));
        chk("p2_err_cnt", 32'(err2), 32'(e.err));
        chk("p2_first_fail", 32'(ff2), 32'(e.ff));
        chk("p2_sig", 32'(sig2), 32'(e.sig));
        chk("p2_pass", 32'(pass2), 32'(e.pass));
        chk("p2_aborted", 32'(ab2), 32'(e.ab));
    endtask

    initial begin
        exp_t e;
        int   n;
        repeat (2) @(negedge clk);
        chk("rst_x_out", 32'(x0), 32'd0);
        chk("rst_err_cnt", 32'(err0), 32'd0);
        chk("rst_sig", 32'(sig0), 32'd0);
        chk("rst_flags", 32'({busy0, done0, pass0, ab0}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep(0, 1'b0, 1'b1);
        sweep(1, 1'b0, 1'b0);
        sweep(2, 1'b0, 1'b0);
        sweep(0, 1'b1, 1'b0);

        // abort while x_out = 10: vectors 0..9 are the only ones compared
        q0.push_back(model(1, 9, 0, 1'b0, 1'b1));
        mode = 1;
        once = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (x0 != N'(10) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_vec10", 32'(x0), 32'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        e = q0.pop_front();
        chk("abort_done", 32'(done0), 32'd1);
        chk("abort_aborted", 32'(ab0), 32'd1);
        chk("abort_pass", 32'(pass0), 32'd0);
        chk("abort_err_cnt", 32'(err0), 32'(e.err));
        chk("abort_first_fail", 32'(ff0), 32'(e.ff));
        chk("abort_sig", 32'(sig0), 32'(e.sig));
        repeat (3) @(negedge clk);
        chk("abort_err_frozen", 32'(err0), 32'(e.err));
        sweep(0, 1'b0, 1'b0);

        // asynchronous reset mid-sweep with errors already accumulated
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_reset_err_nonzero", 32'(err0 != '0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_x_out", 32'(x0), 32'd0);
        chk("async_rst_err_cnt", 32'(err0), 32'd0);
        chk("async_rst_sig", 32'(sig0), 32'd0);
        chk("async_rst_flags", 32'({busy0, done0, pass0, ab0, busy2}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
